seq_divider: RTL

- Multi-cycle integer divider that sits beside the combinational ALU in the execute stage.
- Implements the inverse of the ALU's single-cycle mult: MIPS div/divu.
- Restoring division, one quotient bit per clock; results feed the HI/LO registers.
- The pipeline stalls on busy_o and captures results on done_o.

---
 rtl/seq_divider.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Purpose : multi-cycle restoring divider for MIPS div/divu, one quotient bit per clock.
// Latency : done_o pulses WIDTH+1 edges after the accept edge, independent of operands
//           (zero divisor with SEQ_DIVIDER_ZERO_FAST_EN: 2 edges).
// Backpres: no input handshake; start_i is honoured only while idle (busy_o low) and dropped otherwise.
//
// Optional feature macro: SEQ_DIVIDER_ZERO_FAST_EN
//   defined   -> a zero divisor skips the iteration phase and completes early
//   undefined -> every operation, including divide-by-zero, takes the full latency
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   start_i      request, sampled only when idle
//   signed_i     1 = div (two's complement), 0 = divu; captured with start_i
//   src1_i       dividend (rs); captured with start_i
//   src2_i       divisor (rt); captured with start_i
//   busy_o       high from the accept edge until done_o asserts
//   done_o       one-cycle pulse, results valid
//   quotient_o   quotient (LO), held until the next done_o
//   remainder_o  remainder (HI), held until the next done_o
//   div_zero_o   divisor was zero, updated with done_o and held

module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               neg_dvd_q,   neg_dvd_d;    // dividend was negative (signed op)
  logic               neg_dvs_q,   neg_dvs_d;    // divisor was negative (signed op)
  logic               zero_q,      zero_d;       // divisor was zero
  logic [WIDTH-1:0]   dvs_q,       dvs_d;        // divisor magnitude
  logic [WIDTH-1:0]   dvd_raw_q,   dvd_raw_d;    // untouched dividend for the div-by-zero result
  logic [WIDTH-1:0]   rem_q,       rem_d;        // partial remainder
  logic [WIDTH-1:0]   quo_q,       quo_d;        // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0]   quotient_q,  quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_zero_q,  div_zero_d;
  logic               done_q,      done_d;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept
  // ---------------------------------------------------------------------------
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;

  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1), so no special handling is needed.
  assign src1_neg = signed_i & src1_i[WIDTH-1];
  assign src2_neg = signed_i & src2_i[WIDTH-1];
  assign src1_mag = src1_neg ? -src1_i : src1_i;
  assign src2_mag = src2_neg ? -src2_i : src2_i;

  // ---------------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------------
  // The shifted remainder needs WIDTH+1 bits: rem < divisor before the shift,
  // so after it rem can reach 2*divisor-1, which overflows WIDTH bits for
  // large divisors.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_sub   = rem_shift - {1'b0, dvs_q};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});

  // ---------------------------------------------------------------------------
  // Sign correction applied on the final edge
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quo_fix = (neg_dvd_q ^ neg_dvs_q) ? -quo_q : quo_q;
  assign rem_fix = neg_dvd_q ? -rem_q : rem_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    neg_dvd_d   = neg_dvd_q;
    neg_dvs_d   = neg_dvs_q;
    zero_d      = zero_q;
    dvs_d       = dvs_q;
    dvd_raw_d   = dvd_raw_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          neg_dvd_d = src1_neg;
          neg_dvs_d = src2_neg;
          zero_d    = (src2_i == '0);
          dvs_d     = src2_mag;
          dvd_raw_d = src1_i;
          rem_d     = '0;
          quo_d     = src1_mag;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
          if (src2_i == '0) begin
            // The result is fixed, so iterating is pointless. One counter tick
            // is left so FIX dwells a cycle before completing.
            state_d = ST_FIX;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_INIT;
          end
`else
          state_d   = ST_RUN;
          cnt_d     = CNT_INIT;
`endif
        end
      end

      ST_RUN: begin
        if (rem_ge) begin
          rem_d = rem_sub[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
        if (cnt_q != '0) begin
          // Dwell cycle of the fast zero-divisor path.
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          quotient_d  = zero_q ? '1 : quo_fix;
          remainder_d = zero_q ? dvd_raw_q : rem_fix;
          div_zero_d  = zero_q;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
`else
        // A zero divisor bypasses sign correction: all-ones quotient and the
        // original dividend as remainder, for both div and divu.
        quotient_d  = zero_q ? '1 : quo_fix;
        remainder_d = zero_q ? dvd_raw_q : rem_fix;
        div_zero_d  = zero_q;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      neg_dvd_q   <= 1'b0;
      neg_dvs_q   <= 1'b0;
      zero_q      <= 1'b0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      neg_dvd_q   <= neg_dvd_d;
      neg_dvs_q   <= neg_dvs_d;
      zero_q      <= zero_d;
      dvs_q       <= dvs_d;
      dvd_raw_q   <= dvd_raw_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;

endmodule
